dmem_responder: RTL
===================

# dmem_responder

Synthesizable responder for the processor's data-memory request interface: the memory end of the `dmemreq_*`/`dmemresp_*` protocol the processor drives as initiator. Backs a word-addressed RAM region and a small MMIO region. The MMIO region holds a TX FIFO drained by a valid/ready output port, a status word and an optional cycle counter. Sits between `Proc` and the FPGA top level, replacing the behavioural test memory for data accesses.

## Interface
- `RAM_BASE`, default 32'h0000_2000: byte base address of the RAM region.
- `RAM_WORDS`, default 256: RAM depth in 32-bit words; power of two.
- `MMIO_BASE`, default 32'h0000_F000: byte base address of the MMIO region.
- `FIFO_DEPTH`, default 4: TX FIFO entries; power of two, at least 2.
- `clk`  in  1: clock; all state updates on posedge.
- `rst`  in  1: reset, asynchronous, active-high.
- `dmemreq_val`  in  1: request valid this cycle.
- `dmemreq_type`  in  1: 0 = read, 1 = write.
- `dmemreq_addr`  in  32: byte address.
- `dmemreq_wdata`  in  32: write data.
- `dmemresp_rdata`  out  32: read data, combinational, valid in the same cycle as the request.
- `txout_val`  out  1: TX FIFO head valid.
- `txout_rdy`  in  1: consumer accepts head.
- `txout_data`  out  32: TX FIFO head word.
- `err`  out  1: sticky error flag.

## Operation
- Address decode applies only when `dmemreq_val`=1:
  - RAM hit: `RAM_BASE` <= addr < `RAM_BASE`+4*`RAM_WORDS`; index = (addr-`RAM_BASE`)>>2.
  - MMIO offsets: +0x0 TXDATA, +0x4 STATUS, +0x8 CYCLES.
  - Anything else is unmapped.
- RAM read: `dmemresp_rdata` = mem[index]. RAM write: mem[index] <= wdata at posedge.
- TXDATA write pushes wdata if not full. If full, the push is dropped and sticky `ovf` is set. TXDATA read returns 0.
- STATUS read returns {16'b0, count[7:0], 5'b0, ovf, full, empty}. STATUS write clears `ovf` and `err`.
- Error cases: misaligned access (addr[1:0]!=0) or an unmapped address. Read returns 0, write is dropped, `err` <= 1.
- `dmemresp_rdata` = 0 whenever `dmemreq_val`=0 or the request is a write.
- TX FIFO:
  - `txout_val` = !empty; `txout_data` = head.
  - Pop at posedge when `txout_val`&&`txout_rdy`.
  - Push and pop in the same cycle: both occur and count is unchanged.
  - When full at cycle start, push is dropped even if a pop occurs that cycle (fullness is evaluated before the pop).
  - Pointers wrap modulo `FIFO_DEPTH`. The count field is one bit wider than the pointers so "full" is distinguishable from "empty".

## Timing
- Reads have zero latency: combinational from `dmemreq_*` to `dmemresp_rdata`.
- Writes commit at the next posedge.
- A read in the same cycle as a write to the same word returns the old value.
- A value pushed at posedge N appears on `txout_val`/`txout_data` after posedge N (cycle N+1).
- `txout_data` must hold stable while `txout_val`=1 and `txout_rdy`=0.
- Reset values, applied asynchronously:
  - `txout_val`=0, `txout_data`=0, `err`=0, `ovf`=0.
  - FIFO pointers and count = 0; CYCLES = 0.
- RAM contents are not reset and are undefined after power-up; they are preserved across `rst`.
- Reset asserted mid-operation: FIFO contents are discarded immediately. An in-flight write on the reset edge is not guaranteed to commit.

## Configuration
- `DMEM_RESPONDER_CYCLES_EN` defined:
  - CYCLES is a 32-bit free-running counter, incremented every posedge, wrapping at 2^32.
  - Read returns the current value.
  - Write sets it to wdata. If the write and the increment coincide, the write wins and the counter holds wdata after that posedge.
- Undefined: the CYCLES offset is treated as unmapped (read 0, write dropped, `err` set), and no counter flops exist.

## Structure
- Package `dmem_responder_pkg`:
  - Offset constants `MMIO_TXDATA`, `MMIO_STATUS`, `MMIO_CYCLES`.
  - Request-type constants `DMEM_READ`=0, `DMEM_WRITE`=1.
  - Status bit positions.
- Sub-module `dmem_responder_fifo`: parameterized synchronous FIFO with push, pop, full, empty, count and head, plus async reset. The top level holds the decode, RAM, sticky flags and counter.

## Test plan
- Write 32'hDEAD_BEEF to 0x2004, then read 0x2004 -> rdata = 32'hDEAD_BEEF. A same-cycle read during the write -> old value.
- Push 1, 2, 3 to 0xF000 with `txout_rdy`=0 -> STATUS = 32'h0000_0300; `txout_data`=1 held stable. Then `txout_rdy`=1 -> 1, 2, 3 drained on consecutive cycles, empty=1.
- Push 5 words into a depth-4 FIFO with `txout_rdy`=0 -> fifth word dropped, STATUS = 32'h0000_0406. Write STATUS -> `ovf` cleared.
- Full FIFO with `txout_rdy`=1 and a simultaneous push -> push dropped, count = 3 after the edge. Half-full with push and pop together -> count unchanged.
- Read 0x2001 (misaligned) and write 0x8000 (unmapped) -> rdata = 0, RAM unchanged, `err`=1 until a STATUS write.
- With `DMEM_RESPONDER_CYCLES_EN`: write 100 to 0xF008 -> reads 102 two cycles later. Assert `rst` mid-drain -> `txout_val`=0 immediately, CYCLES = 0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared constants, decode target type and status packing for dmem_responder.
package dmem_responder_pkg;

  localparam logic [31:0] MMIO_TXDATA = 32'h0000_0000;
  localparam logic [31:0] MMIO_STATUS = 32'h0000_0004;
  localparam logic [31:0] MMIO_CYCLES = 32'h0000_0008;

  localparam logic DMEM_READ  = 1'b0;
  localparam logic DMEM_WRITE = 1'b1;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 8;

  typedef enum logic [2:0] {
    TGT_NONE,
    TGT_RAM,
    TGT_TXDATA,
    TGT_STATUS,
    TGT_CYCLES,
    TGT_ERROR
  } target_e;

  function automatic logic [31:0] pack_status(input logic [7:0] count,
                                              input logic       ovf,
                                              input logic       full,
                                              input logic       empty);
    logic [31:0] s;
    s = '0;
    s[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    s[STAT_OVF_BIT]   = ovf;
    s[STAT_FULL_BIT]  = full;
    s[STAT_EMPTY_BIT] = empty;
    return s;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus plus TX output port and error flag.
interface dmem_responder_if;
  logic        dmemreq_val;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic [31:0] dmemresp_rdata;
  logic        txout_val;
  logic        txout_rdy;
  logic [31:0] txout_data;
  logic        err;

  modport master (
    output dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata, txout_rdy,
    input  dmemresp_rdata, txout_val, txout_data, err
  );

  modport slave (
    input  dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata, txout_rdy,
    output dmemresp_rdata, txout_val, txout_data, err
  );
endinterface

// File: rtl/dmem_responder_fifo.sv
// Synchronous power-of-two FIFO; fullness is judged before a same-cycle pop.
module dmem_responder_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [WIDTH-1:0]       o_head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  // NOTE: storage is deliberately not reset; the head is gated by empty, so
  // stale entries are never visible and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values;
  // blocking ones here would let the count see already-moved pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;
  assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, TX FIFO MMIO, sticky error/overflow flags.
// Optional cycle counter enabled by defining DMEM_RESPONDER_CYCLES_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter logic [31:0] RAM_BASE   = 32'h0000_2000,
  parameter int          RAM_WORDS  = 256,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_F000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  logic [31:0]      r_mem [RAM_WORDS];
  logic             r_err;
  logic             r_ovf;

  target_e          w_target;
  logic             w_is_wr;
  logic [31:0]      w_ram_off;
  logic             w_ram_hit;
  logic [IDX_W-1:0] w_ram_idx;
  logic [31:0]      w_rdata;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [31:0]      w_head;

  assign w_is_wr   = (bus.dmemreq_type == DMEM_WRITE);
  assign w_ram_off = bus.dmemreq_addr - RAM_BASE;
  assign w_ram_hit = (bus.dmemreq_addr >= RAM_BASE) && (w_ram_off < RAM_BYTES);
  assign w_ram_idx = IDX_W'(w_ram_off >> 2);

  // NOTE: the default target is assigned first so every path through this
  // block drives w_target and no latch is inferred.
  always_comb begin
    w_target = TGT_NONE;
    if (bus.dmemreq_val) begin
      if (bus.dmemreq_addr[1:0] != 2'b00)                     w_target = TGT_ERROR;
      else if (w_ram_hit)                                      w_target = TGT_RAM;
      else if (bus.dmemreq_addr == MMIO_BASE + MMIO_TXDATA)    w_target = TGT_TXDATA;
      else if (bus.dmemreq_addr == MMIO_BASE + MMIO_STATUS)    w_target = TGT_STATUS;
`ifdef DMEM_RESPONDER_CYCLES_EN
      else if (bus.dmemreq_addr == MMIO_BASE + MMIO_CYCLES)    w_target = TGT_CYCLES;
`endif
      else                                                     w_target = TGT_ERROR;
    end
  end

`ifdef DMEM_RESPONDER_CYCLES_EN
  logic [31:0] r_cycles;

  // A software write takes priority over the free-running increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycles <= '0;
    end else if (w_target == TGT_CYCLES && w_is_wr) begin
      r_cycles <= bus.dmemreq_wdata;
    end else begin
      r_cycles <= r_cycles + 32'd1;
    end
  end
`endif

  always_comb begin
    w_rdata = '0;
    if (!w_is_wr) begin
      case (w_target)
        TGT_RAM:    w_rdata = r_mem[w_ram_idx];
        TGT_STATUS: w_rdata = pack_status(8'(w_count), r_ovf, w_full, w_empty);
`ifdef DMEM_RESPONDER_CYCLES_EN
        TGT_CYCLES: w_rdata = r_cycles;
`endif
        default:    w_rdata = '0;
      endcase
    end
  end

  // RAM survives rst, so this array has no reset branch.
  always_ff @(posedge clk) begin
    if (w_target == TGT_RAM && w_is_wr) r_mem[w_ram_idx] <= bus.dmemreq_wdata;
  end

  assign w_push = (w_target == TGT_TXDATA) && w_is_wr;
  assign w_pop  = !w_empty && bus.txout_rdy;

  dmem_responder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (bus.dmemreq_wdata),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_target == TGT_STATUS && w_is_wr) begin
        r_err <= 1'b0;
        r_ovf <= 1'b0;
      end
      if (w_target == TGT_ERROR) r_err <= 1'b1;
      if (w_push && w_full)      r_ovf <= 1'b1;
    end
  end

  assign bus.dmemresp_rdata = w_rdata;
  assign bus.txout_val      = !w_empty;
  assign bus.txout_data     = w_head;
  assign bus.err            = r_err;

endmodule
